// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed RV32 load/store unit with req/ready handshake, registered response and fault detection
module data_memory_lsu #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 32,
    parameter bit INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wd,
    output logic                  ready,
    output logic                  ack,
    output logic [31:0]           rd,
    output logic [2:0]            fault
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {CLEAR, START, READY} state_t;
    state_t state, state_n;
    logic [AW-1:0] ptr, idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] word, wdata, ext;
    logic [3:0] be;
    logic [1:0] off;
    logic [7:0] b;
    logic [15:0] h;
    logic acc, oor, ill, mis;
    logic [2:0] flt;
    assign ready = state == READY;
    assign acc   = ready && req;
    assign off   = addr[1:0];
    assign idx   = addr[AW+1:2];
    assign oor   = (addr >> (AW + 2)) != '0;
    assign ill   = we ? (funct3 != 3'd0 && funct3 != 3'd1 && funct3 != 3'd2)
                      : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
    assign mis   = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    assign flt   = {ill, oor, mis};
    assign word  = mem[idx];
    assign b     = 8'(word >> {off, 3'b000});
    assign h     = 16'(word >> {off[1], 4'b0000});
    // Lane enables and lane-replicated store data; halfwords are aligned so replication lands in the right lanes
    always_comb begin
        be    = funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata = funct3[1:0] == 2'b00 ? {4{wd[7:0]}} : funct3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
        ext   = funct3 == 3'b000 ? {{24{b[7]}}, b} :
                funct3 == 3'b001 ? {{16{h[15]}}, h} :
                funct3 == 3'b100 ? {24'b0, b} :
                funct3 == 3'b101 ? {16'b0, h} : word;
    end
    // Next state: walk the clear pointer to the last word, or skip straight to READY
    always_comb begin
        state_n = state;
        if (state == CLEAR) state_n = &ptr ? READY : CLEAR;
        else if (state == START) state_n = READY;
    end
    // State, clear pointer and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT_CLEAR ? CLEAR : START;
            ptr   <= '0;
            ack   <= 1'b0;
            rd    <= '0;
            fault <= '0;
        end else begin
            state <= state_n;
            ptr   <= state == CLEAR ? ptr + 1'b1 : '0;
            ack   <= acc;
            fault <= acc ? flt : 3'b000;
            if (acc && !we) rd <= |flt ? 32'b0 : ext;
        end
    end
    // Array writes: zero-fill during clear, byte-enabled stores at the acceptance edge
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) mem[ptr] <= '0;
        else if (!rst && acc && we && flt == 3'b000)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
    end
endmodule
